// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
package lsu_pkg;

  localparam int MEM_WORDS_DEFAULT  = 4096;
  localparam int WORD_IDX_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: extracts and extends a lane for loads and
// splices store data into a read word for sub-word stores (little-endian).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_val,
  output logic [31:0] o_merged_word
);

  size_e       w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size = size_e'(i_size);

  // Pick out the addressed byte lane and halfword lane of the memory word
  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  // Right-justify the selected lane and fill the upper bits with sign or zeros
  always_comb begin
    o_load_val = i_word;
    case (w_size)
      SZ_BYTE: o_load_val = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_val = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load_val = i_word;
    endcase
  end

  // Overwrite only the addressed lane, keeping the other bytes as read
  always_comb begin
    o_merged_word = i_word;
    case (w_size)
      SZ_BYTE: begin
        case (i_addr_lo)
          2'd1:    o_merged_word[15:8]  = i_wdata[7:0];
          2'd2:    o_merged_word[23:16] = i_wdata[7:0];
          2'd3:    o_merged_word[31:24] = i_wdata[7:0];
          default: o_merged_word[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_addr_lo[1]) o_merged_word[31:16] = i_wdata[15:0];
        else              o_merged_word[15:0]  = i_wdata[15:0];
      end
      default: o_merged_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide data memory without byte enables.
// Sub-word stores are done as read-modify-write; every request gets exactly
// one response pulse unless reset intervenes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int WORD_IDX_W = WORD_IDX_W_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  state_e                r_state;
  state_e                w_next_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [WORD_IDX_W+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  w_req_err;
  logic                  w_accept;
  logic [31:0]           w_word_idx;
  logic [31:0]           w_load_val;
  logic [31:0]           w_merged_word;

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_word_idx = {{(32-WORD_IDX_W){1'b0}}, r_addr[WORD_IDX_W+1:2]};

  // Classify the incoming request as illegal before any memory access is made
  always_comb begin
    w_req_err = 1'b0;
    case (size_e'(req_size))
      SZ_HALF: w_req_err = req_addr[0];
      SZ_WORD: w_req_err = (req_addr[1:0] != 2'b00);
      SZ_BAD:  w_req_err = 1'b1;
      default: w_req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) w_req_err = 1'b1;
  end

  lsu_lane_align u_lane_align (
    .i_word        (mem_rdata),
    .i_addr_lo     (r_addr[1:0]),
    .i_size        (r_size),
    .i_signed      (r_signed),
    .i_wdata       (r_wdata),
    .o_load_val    (w_load_val),
    .o_merged_word (w_merged_word)
  );

  // State register; reset abandons whatever request is in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Sequencing of the memory phases and decode of all port strobes from state
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = 32'd0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                            w_next_state = RESP;
          else if (!req_we)                         w_next_state = RD;
          else if (size_e'(req_size) == SZ_WORD)    w_next_state = WR;
          else                                      w_next_state = RD;
        end
      end
      RD: begin
        mem_rd       = 1'b1;
        mem_addr     = w_word_idx;
        w_next_state = CAP;
      end
      CAP: begin
        mem_addr     = w_word_idx;
        w_next_state = r_we ? WR : RESP;
      end
      WR: begin
        mem_wr       = 1'b1;
        mem_addr     = w_word_idx;
        mem_wdata    = r_wdata;
        w_next_state = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_err     = r_err;
        resp_rdata   = r_rdata;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Capture the request on accept, then fold the read word in during CAP
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr[WORD_IDX_W+1:0];
      r_wdata  <= req_wdata;
      r_rdata  <= 32'd0;
      r_err    <= w_req_err;
    end else if (r_state == CAP) begin
      if (r_we) r_wdata <= w_merged_word;
      else      r_rdata <= w_load_val;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a synchronous word memory model
// and a queue of expected responses.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int hi_addr = 0;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
    logic [1:0]  nrd;
    logic [1:0]  nwr;
  } resp_t;

  typedef struct packed {
    req_t        rq;
    resp_t       rs;
    logic [31:0] era;
    logic [31:0] ewa;
    logic [31:0] ewd;
  } case_t;

  resp_t sbq[$];

  load_store_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Data memory: read data appears the cycle after mem_rd is sampled
  logic [31:0] mem [0:4095];
  bit preloaded;
  always @(posedge CLK) begin
    if (!preloaded) begin
      mem[0]    <= 32'd12;
      mem[8]    <= 32'h1122_3344;
      mem[4095] <= 32'hA5A5_5A5A;
      preloaded <= 1'b1;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];
    if (mem_wr) mem[mem_addr[11:0]] <= mem_wdata;
  end

  // Watch for strobe overlap and stray high address bits throughout the run
  always @(negedge CLK) begin
    if (mem_rd && mem_wr) overlap++;
    if (mem_addr[31:12] != 20'd0) hi_addr++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time limit reached, required finish earlier");
    $fatal(1, "[TB] timeout");
  end

  function automatic case_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err, input int lat,
                               input int nrd, input int nwr, input logic [31:0] era,
                               input logic [31:0] ewa, input logic [31:0] ewd);
    case_t c;
    c.rq.we = we; c.rq.size = size; c.rq.sgn = sgn; c.rq.addr = addr; c.rq.wdata = wdata;
    c.rs.rdata = rdata; c.rs.err = err; c.rs.lat = 4'(lat);
    c.rs.nrd = 2'(nrd); c.rs.nwr = 2'(nwr);
    c.era = era; c.ewa = ewa; c.ewd = ewd;
    return c;
  endfunction

  // Drive one request, scramble the request bus after acceptance, and observe
  task automatic issue(input req_t rq, output resp_t o, output logic [31:0] ra,
                       output logic [31:0] wa, output logic [31:0] wd);
    int wait_cnt;
    o = '0; ra = '0; wa = '0; wd = '0;
    @(negedge CLK);
    req_valid = 1'b1; req_we = rq.we; req_size = rq.size; req_signed = rq.sgn;
    req_addr = rq.addr; req_wdata = rq.wdata;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(negedge CLK);
      wait_cnt++;
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_we = ~rq.we; req_size = ~rq.size; req_signed = ~rq.sgn;
    req_addr = 32'hFFFF_FFFF; req_wdata = ~rq.wdata;
    while (o.lat < 4'd12) begin
      @(negedge CLK);
      o.lat = o.lat + 4'd1;
      if (mem_rd) begin o.nrd = o.nrd + 2'd1; ra = mem_addr; end
      if (mem_wr) begin o.nwr = o.nwr + 2'd1; wa = mem_addr; wd = mem_wdata; end
      if (resp_valid) begin o.rdata = resp_rdata; o.err = resp_err; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_rd, mem_wr, resp_rdata, mem_addr, mem_wdata} !== {1'b1, 100'd0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, required ready=1 and all else 0",
               req_ready, resp_valid, resp_err, mem_rd, mem_wr, resp_rdata, mem_addr, mem_wdata);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({req_ready, resp_valid, mem_rd, mem_wr} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_release: got ready/rv/rd/wr=%b, required 1000", {req_ready, resp_valid, mem_rd, mem_wr});
    end
  endtask

  task automatic test_word_load();
    case_t tc;
    resp_t o, e;
    logic [31:0] ra, wa, wd;
    tc = mk(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'd12, 1'b0, 3, 1, 0, 32'd0, 32'd0, 32'd0);
    sbq.push_back(tc.rs);
    issue(tc.rq, o, ra, wa, wd);
    e = sbq.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL word_load resp: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d, required rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
               o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
    end
    checks++;
    if ({ra, wa, wd} !== {tc.era, tc.ewa, tc.ewd}) begin
      errors++;
      $display("[TB] FAIL word_load mem_port: got rd_addr=%h wr_addr=%h wr_data=%h, required %h %h %h",
               ra, wa, wd, tc.era, tc.ewa, tc.ewd);
    end
  endtask

  task automatic test_store_and_subword_loads();
    case_t tc[6];
    resp_t o, e;
    logic [31:0] ra, wa, wd;
    tc[0] = mk(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'd0, 32'd4, 32'hDEADBEEF);
    tc[1] = mk(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    tc[2] = mk(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    tc[3] = mk(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    tc[4] = mk(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    tc[5] = mk(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      sbq.push_back(tc[i].rs);
      issue(tc[i].rq, o, ra, wa, wd);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL store_loads[%0d] resp: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d, required rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 i, o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
      checks++;
      if ({ra, wa, wd} !== {tc[i].era, tc[i].ewa, tc[i].ewd}) begin
        errors++;
        $display("[TB] FAIL store_loads[%0d] mem_port: got rd_addr=%h wr_addr=%h wr_data=%h, required %h %h %h",
                 i, ra, wa, wd, tc[i].era, tc[i].ewa, tc[i].ewd);
      end
    end
  endtask

  task automatic test_subword_store();
    case_t tc[6];
    resp_t o, e;
    logic [31:0] ra, wa, wd;
    tc[0] = mk(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hAAAAAA55, 32'h0,        1'b0, 4, 1, 1, 32'd4, 32'd4, 32'hDEAD55EF);
    tc[1] = mk(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    tc[2] = mk(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF1234, 32'h0,        1'b0, 4, 1, 1, 32'd4, 32'd4, 32'h123455EF);
    tc[3] = mk(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'h123455EF, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    tc[4] = mk(1'b1, SZ_BYTE, 1'b1, 32'h13, 32'h00000080, 32'h0,        1'b0, 4, 1, 1, 32'd4, 32'd4, 32'h803455EF);
    tc[5] = mk(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        32'hFFFF8034, 1'b0, 3, 1, 0, 32'd4, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      sbq.push_back(tc[i].rs);
      issue(tc[i].rq, o, ra, wa, wd);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL subword_store[%0d] resp: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d, required rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 i, o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
      checks++;
      if ({ra, wa, wd} !== {tc[i].era, tc[i].ewa, tc[i].ewd}) begin
        errors++;
        $display("[TB] FAIL subword_store[%0d] mem_port: got rd_addr=%h wr_addr=%h wr_data=%h, required %h %h %h",
                 i, ra, wa, wd, tc[i].era, tc[i].ewa, tc[i].ewd);
      end
    end
  endtask

  task automatic test_errors_and_range();
    case_t tc[8];
    resp_t o, e;
    logic [31:0] ra, wa, wd;
    tc[0] = mk(1'b0, SZ_HALF, 1'b0, 32'h3,        32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd0,     32'd0, 32'd0);
    tc[1] = mk(1'b1, SZ_WORD, 1'b0, 32'h2,        32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'd0,     32'd0, 32'd0);
    tc[2] = mk(1'b0, SZ_BAD,  1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd0,     32'd0, 32'd0);
    tc[3] = mk(1'b0, SZ_WORD, 1'b0, 32'h4000,     32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd0,     32'd0, 32'd0);
    tc[4] = mk(1'b1, SZ_BYTE, 1'b0, 32'hFFFFFFFF, 32'h11,       32'h0,        1'b1, 1, 0, 0, 32'd0,     32'd0, 32'd0);
    tc[5] = mk(1'b0, SZ_WORD, 1'b0, 32'h3FFC,     32'h0,        32'hA5A55A5A, 1'b0, 3, 1, 0, 32'hFFF,   32'd0, 32'd0);
    tc[6] = mk(1'b0, SZ_BYTE, 1'b0, 32'h3FFF,     32'h0,        32'h000000A5, 1'b0, 3, 1, 0, 32'hFFF,   32'd0, 32'd0);
    tc[7] = mk(1'b0, SZ_HALF, 1'b1, 32'h3FFE,     32'h0,        32'hFFFFA5A5, 1'b0, 3, 1, 0, 32'hFFF,   32'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      sbq.push_back(tc[i].rs);
      issue(tc[i].rq, o, ra, wa, wd);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL errors[%0d] resp: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d, required rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
                 i, o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
      end
      checks++;
      if ({ra, wa, wd} !== {tc[i].era, tc[i].ewa, tc[i].ewd}) begin
        errors++;
        $display("[TB] FAIL errors[%0d] mem_port: got rd_addr=%h wr_addr=%h wr_data=%h, required %h %h %h",
                 i, ra, wa, wd, tc[i].era, tc[i].ewa, tc[i].ewd);
      end
    end
  endtask

  task automatic test_reset_during_write();
    int nresp;
    resp_t o, e;
    logic [31:0] ra, wa, wd;
    req_t rq;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (mem_wr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_wr_phase: got mem_wr=%b, required 1", mem_wr);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({mem_wr, mem_rd, resp_valid, req_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rst_async_drop: got wr/rd/rv/ready=%b, required 0001", {mem_wr, mem_rd, resp_valid, req_ready});
    end
    nresp = 0;
    repeat (3) begin
      @(negedge CLK);
      if (resp_valid) nresp++;
    end
    RST = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (resp_valid) nresp++;
    end
    checks++;
    if (nresp !== 0) begin
      errors++;
      $display("[TB] FAIL rst_no_resp: got %0d responses, required 0", nresp);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_ready: got %b, required 1", req_ready);
    end
    checks++;
    if (mem[8] !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL rst_mem_word8: got %h, required 11223344", mem[8]);
    end
    rq = '{we: 1'b0, size: SZ_WORD, sgn: 1'b0, addr: 32'h20, wdata: 32'h0};
    sbq.push_back('{rdata: 32'h11223344, err: 1'b0, lat: 4'd3, nrd: 2'd1, nwr: 2'd0});
    issue(rq, o, ra, wa, wd);
    e = sbq.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL rst_reload resp: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d, required rdata=%h err=%b lat=%0d rd=%0d wr=%0d",
               o.rdata, o.err, o.lat, o.nrd, o.nwr, e.rdata, e.err, e.lat, e.nrd, e.nwr);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, npulse, first, second;
    resp_t e;
    sbq.push_back('{rdata: 32'h803455EF, err: 1'b0, lat: 4'd3, nrd: 2'd1, nwr: 2'd0});
    sbq.push_back('{rdata: 32'h803455EF, err: 1'b0, lat: 4'd3, nrd: 2'd1, nwr: 2'd0});
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    accepts = 0; npulse = 0; first = -1; second = -1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge CLK);
      if (req_ready && req_valid) accepts++;
      if (resp_valid) begin
        npulse++;
        if (first < 0) first = c;
        else second = c;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checks++;
          if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin
            errors++;
            $display("[TB] FAIL b2b_resp@%0d: got rdata=%h err=%b, required rdata=%h err=%b",
                     c, resp_rdata, resp_err, e.rdata, e.err);
          end
        end
      end
      if (c == 7) req_valid = 1'b0;
    end
    sbq.delete();
    checks++;
    if (accepts !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_accepts: got %0d ready cycles with valid held, required 2", accepts);
    end
    checks++;
    if ({npulse, first, second} !== {32'd2, 32'd3, 32'd7}) begin
      errors++;
      $display("[TB] FAIL b2b_timing: got pulses=%0d at cycles %0d and %0d, required 2 at 3 and 7", npulse, first, second);
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    $display("[TB] load_store_unit bench starting");
    test_reset();
    test_word_load();
    test_store_and_subword_loads();
    test_subword_store();
    test_errors_and_range();
    test_reset_during_write();
    test_back_to_back();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("[TB] FAIL rd_wr_overlap: got %0d cycles with both strobes, required 0", overlap);
    end
    checks++;
    if (hi_addr !== 0) begin
      errors++;
      $display("[TB] FAIL mem_addr_high: got %0d cycles with nonzero upper bits, required 0", hi_addr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage sitting directly upstream of the data memory. It turns byte-addressed load/store requests from the execute stage into word-wide rd/wr/address/data transactions on the data memory port.
- The data memory is word-wide with no byte enables, so the block performs read-modify-write for sub-word stores. It aligns and sign/zero-extends sub-word loads.
- Returns one response per request to the writeback stage.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the data memory; legal byte addresses are 0 to 4*MEM_WORDS-1.
- WORD_IDX_W, 12, log2(MEM_WORDS); width of the word index driven on mem_addr.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse, response available.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; request was misaligned, out of range or illegal size.
- mem_rd  out  1  to data memory rd.
- mem_wr  out  1  to data memory wr.
- mem_addr  out  32  word index {zeros, addr[WORD_IDX_W+1:2]}.
- mem_wdata  out  32  to data memory d_in.
- mem_rdata  in  32  from data memory d_out; valid the cycle after the edge at which mem_rd was sampled high.

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. State = IDLE.
- RST is asynchronous, so asserting it during any state drops mem_wr/mem_rd immediately. No write is issued at the next edge and any in-flight request is discarded without a response.
- States:
  - IDLE: req_ready = 1. The request is accepted on an edge where req_valid = 1. All request fields are captured into registers, and nothing is sampled from req_* afterwards.
  - RD: mem_rd = 1, mem_addr = word index.
  - CAP: mem_rdata is valid. A load extracts its lane, extends it and registers the result into resp_rdata. A sub-word store merges its bytes into the read word and registers the result into mem_wdata.
  - WR: mem_wr = 1, mem_addr = word index, mem_wdata = merged or full word.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Transitions out of IDLE on accept:
  - Error → RESP with resp_err = 1.
  - Load → RD → CAP → RESP.
  - Word store → WR → RESP.
  - Byte/half store → RD → CAP → WR → RESP.
- Latency, counted from the accepting edge to resp_valid high:
  - Error: 1 cycle.
  - Word store: 2 cycles.
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
- Error conditions (checked in IDLE; no memory access):
  - req_size = 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] ≠ 0.
  - addr ≥ 4*MEM_WORDS.
- Lane selection uses little-endian byte order:
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Extension: sign fill from the lane MSB when req_signed = 1, zero fill otherwise. req_signed is ignored for word loads and for stores.
- Store merge: only the addressed byte/half is replaced, using the low bits of req_wdata. All other bytes keep the values read from memory.
- mem_rd and mem_wr are never high in the same cycle. mem_addr holds the word index in RD, CAP and WR and is 0 otherwise.
- req_valid while busy: ignored, and req_ready stays 0. The requester must hold the request until it sees req_ready.
- A new request can be accepted in the cycle after RESP. Back-to-back throughput is one request per latency+1 cycles.

Decomposition:
- lsu_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD.
  - State enum {IDLE, RD, CAP, WR, RESP}.
  - MEM_WORDS default.
- One combinational sub-module, lsu_lane_align, does load extract/extend and store merge:
  - Inputs: word, addr[1:0], size, signed, wdata.
  - Outputs: load_val, merged_word.
  - The FSM and registers stay in load_store_unit.

Test Plan:
- Memory word 0 preloaded with 12. Load word addr 0x0 → mem_rd high one cycle with mem_addr = 0; resp_valid 3 cycles after accept; resp_rdata = 12, resp_err = 0.
- Word store 0xDEADBEEF to addr 0x10 → mem_wr high one cycle, mem_addr = 4, mem_wdata = 0xDEADBEEF, resp 2 cycles after accept. Then signed byte load addr 0x13 → resp_rdata = 0xFFFFFFDE; unsigned half load addr 0x10 → 0x0000BEEF.
- With word 4 = 0xDEADBEEF, byte store 0x55 to addr 0x11 → RD then WR, mem_wdata = 0xDEAD55EF, resp 4 cycles after accept. A subsequent word load returns 0xDEAD55EF.
- Half load addr 0x3, word store addr 0x2, size 11, and load addr 0x4000 → each: resp_err = 1 one cycle after accept; mem_rd and mem_wr never asserted; resp_rdata = 0.
- Assert RST during WR of a word store to addr 0x20 → mem_wr falls in the same cycle, memory word 8 is unchanged, no resp_valid; after release, req_ready = 1 and a load of 0x20 returns the old value.
- req_valid held high across a load → exactly one acceptance per IDLE visit, req_ready low in RD/CAP/RESP, two back-to-back loads produce two resp_valid pulses 4 cycles apart.
